conv_pe: RTL

CONV_PE -- requirements
Module: conv_pe

---
 rtl/conv_pe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/conv_pe.sv
// Convolution processing element: TAPS-wide signed-weight x unsigned-pixel
// dot product per beat, accumulated over a group, then shifted, optionally
// ReLU-clamped and saturated. Two-stage pipeline with one global stall.

// Per-tap multiplier: zero-extended pixel times signed weight, sign-extended
// to the accumulator width.
module conv_pe_tap #(
  parameter int PW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 24
) (
  input  logic [WW-1:0]    w,
  input  logic [PW-1:0]    pix,
  output logic [ACC_W-1:0] prod
);
  logic signed [WW+PW:0] mul;

  assign mul  = $signed(w) * $signed({1'b0, pix});
  assign prod = {{(ACC_W-WW-PW-1){mul[WW+PW]}}, mul};
endmodule

module conv_pe #(
  parameter int TAPS  = 3,
  parameter int PW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 24,
  parameter int OW    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 w_load,
  input  logic [WW-1:0]        w_data,
  input  logic [TAPS*PW-1:0]   p,
  input  logic                 p_valid,
  input  logic                 p_last,
  output logic                 p_ready,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic [OW-1:0]        o,
  output logic                 o_valid,
  input  logic                 o_ready
);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef struct packed {
    logic             last;
    logic [4:0]       shift;
    logic             relu;
    logic [ACC_W-1:0] sum;
  } s1_t;

  logic [TAPS-1:0][WW-1:0]    w;
  logic [TAPS-1:0][ACC_W-1:0] prod;
  logic [ACC_W-1:0]           sum;
  logic                       en;
  logic [1:0]                 vld_pipe;   // [0] stage-1 beat, [1] result
  s1_t                        s1;
  logic signed [ACC_W-1:0]    acc, tot, shd, r;

  // Only a pending result that downstream refuses stalls the pipe.
  assign en      = !(vld_pipe[1] && !o_ready);
  assign p_ready = en;
  assign o_valid = vld_pipe[1];

  // Tap 0 lives in the most-significant pixel slice.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    conv_pe_tap #(.PW(PW), .WW(WW), .ACC_W(ACC_W)) u_tap (
      .w    (w[k]),
      .pix  (p[(TAPS-1-k)*PW +: PW]),
      .prod (prod[k])
    );
  end

  // Adder tree over the tap products.
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + prod[k];
  end

  // Weight shift chain; never stalled, and the beat seen on the same edge
  // has already used the old weights combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w <= '0;
    end else if (w_load) begin
      for (int k = 0; k < TAPS-1; k++) w[k] <= w[k+1];
      w[TAPS-1] <= w_data;
    end
  end

  // Group close-out: floor shift, optional ReLU, saturate to OW bits.
  always_comb begin
    tot = acc + $signed(s1.sum);
    shd = tot >>> s1.shift;
    r   = shd;
    if (s1.relu && shd < 0) r = '0;
    if (r > OMAX)      r = OMAX;
    else if (r < OMIN) r = OMIN;
  end

  // Stage 1 captures the beat sum and tags; stage 2 accumulates or emits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      s1       <= '0;
      acc      <= '0;
      o        <= '0;
    end else if (en) begin
      vld_pipe[0] <= p_valid;
      s1          <= '{last: p_last, shift: shift, relu: relu_en, sum: sum};
      vld_pipe[1] <= vld_pipe[0] && s1.last;
      if (vld_pipe[0]) begin
        if (s1.last) begin
          o   <= r[OW-1:0];
          acc <= '0;
        end else begin
          acc <= tot;
        end
      end
    end
  end
endmodule
